// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side instruction fields, forwarding sources from
// EX/MEM and MEM/WB, and the operands/control presented to the EX stage.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    // Instruction arriving from ID
    logic          id_valid;
    logic [31:0]   id_pc;
    logic [RW-1:0] id_rs_addr;
    logic [RW-1:0] id_rt_addr;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [RW-1:0] id_dest;
    logic [15:0]   id_imm;
    logic [RW-1:0] id_shamt;
    logic [3:0]    id_aluc;
    logic [2:0]    id_src;
    logic [3:0]    id_ctrl;
    logic [1:0]    id_use;

    // Pipeline control
    logic          flush;
    logic          stall_in;

    // Forwarding sources
    logic          exm_wr;
    logic [RW-1:0] exm_dest;
    logic [DW-1:0] exm_data;
    logic          wb_wr;
    logic [RW-1:0] wb_dest;
    logic [DW-1:0] wb_data;

    // EX-side results
    logic          stall_out;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_aluc;
    logic          ex_valid;
    logic [31:0]   ex_pc;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_dest;
    logic [3:0]    ex_ctrl;

    // Upstream pipeline / environment side
    modport master (
        output id_valid, id_pc, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
               id_dest, id_imm, id_shamt, id_aluc, id_src, id_ctrl, id_use,
               flush, stall_in, exm_wr, exm_dest, exm_data, wb_wr, wb_dest, wb_data,
        input  stall_out, alu_a, alu_b, alu_aluc, ex_valid, ex_pc,
               ex_store_data, ex_dest, ex_ctrl
    );

    // The ID/EX stage itself
    modport slave (
        input  id_valid, id_pc, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
               id_dest, id_imm, id_shamt, id_aluc, id_src, id_ctrl, id_use,
               flush, stall_in, exm_wr, exm_dest, exm_data, wb_wr, wb_dest, wb_data,
        output stall_out, alu_a, alu_b, alu_aluc, ex_valid, ex_pc,
               ex_store_data, ex_dest, ex_ctrl
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and EX operand front end: captures the decoded
// instruction, forwards from EX/MEM (preferred) and MEM/WB, detects
// load-use hazards and builds the ALU operands.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);
    // Bit positions inside the packed control fields
    localparam int CTRL_MEM_READ = 2;  // {reg_write, mem_read, mem_write, mem_to_reg}
    localparam int SRC_SEXT      = 2;  // {sext, a_is_shamt, b_is_imm}
    localparam int SRC_SHAMT     = 1;
    localparam int SRC_IMM       = 0;
    localparam int USE_RS        = 1;  // {uses_rs, uses_rt}
    localparam int USE_RT        = 0;

    // Captured instruction
    logic          ex_valid_q;
    logic [31:0]   pc_q;
    logic [RW-1:0] rs_addr_q;
    logic [RW-1:0] rt_addr_q;
    logic [DW-1:0] rs_val_q;
    logic [DW-1:0] rt_val_q;
    logic [RW-1:0] dest_q;
    logic [15:0]   imm_q;
    logic [RW-1:0] shamt_q;
    logic [3:0]    aluc_q;
    logic [2:0]    src_q;
    logic [3:0]    ctrl_q;

    logic          load_use;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;
    logic [DW-1:0] imm_ext;

    // Load in EX whose destination the ID instruction reads: one bubble needed
    always_comb begin
        load_use = ex_valid_q && ctrl_q[CTRL_MEM_READ] && (dest_q != '0) && bus.id_valid &&
                   ((bus.id_use[USE_RS] && (bus.id_rs_addr == dest_q)) ||
                    (bus.id_use[USE_RT] && (bus.id_rt_addr == dest_q)));
    end

    assign bus.stall_out = bus.stall_in | load_use;

    // Operand forwarding: the younger EX/MEM result wins; $0 is never forwarded
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        fwd_rs = rs_val_q;
        fwd_rt = rt_val_q;
        if ((rs_addr_q != '0) && bus.exm_wr && (bus.exm_dest == rs_addr_q))
            fwd_rs = bus.exm_data;
        else if ((rs_addr_q != '0) && bus.wb_wr && (bus.wb_dest == rs_addr_q))
            fwd_rs = bus.wb_data;
        if ((rt_addr_q != '0) && bus.exm_wr && (bus.exm_dest == rt_addr_q))
            fwd_rt = bus.exm_data;
        else if ((rt_addr_q != '0) && bus.wb_wr && (bus.wb_dest == rt_addr_q))
            fwd_rt = bus.wb_data;
    end

    // Immediate extension and ALU operand selection
    always_comb begin
        imm_ext = src_q[SRC_SEXT] ? {{(DW-16){imm_q[15]}}, imm_q}
                                  : {{(DW-16){1'b0}}, imm_q};
        bus.alu_a = src_q[SRC_SHAMT] ? {{(DW-RW){1'b0}}, shamt_q} : fwd_rs;
        bus.alu_b = src_q[SRC_IMM] ? imm_ext : fwd_rt;
    end

    assign bus.ex_store_data = fwd_rt;
    assign bus.alu_aluc      = aluc_q;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_pc         = pc_q;
    assign bus.ex_dest       = dest_q;
    assign bus.ex_ctrl       = ctrl_q;

    // Pipeline register update, priority flush > stall_in > load-use > load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            ex_valid_q <= 1'b0;
            pc_q       <= '0;
            rs_addr_q  <= '0;
            rt_addr_q  <= '0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            dest_q     <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            aluc_q     <= '0;
            src_q      <= '0;
            ctrl_q     <= '0;
        end else if (bus.flush) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
        end else if (bus.stall_in) begin
            // Hold, but latch forwarded operands so a producer retiring
            // during the stall is not lost.
            rs_val_q <= fwd_rs;
            rt_val_q <= fwd_rt;
        end else if (load_use) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            ex_valid_q <= bus.id_valid;
            pc_q       <= bus.id_pc;
            rs_addr_q  <= bus.id_rs_addr;
            rt_addr_q  <= bus.id_rt_addr;
            rs_val_q   <= bus.id_rs_data;
            rt_val_q   <= bus.id_rt_data;
            dest_q     <= bus.id_dest;
            imm_q      <= bus.id_imm;
            shamt_q    <= bus.id_shamt;
            aluc_q     <= bus.id_aluc;
            src_q      <= bus.id_src;
            ctrl_q     <= bus.id_valid ? bus.id_ctrl : 4'b0000;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a transaction-level model of the EX
// slot checked every cycle, plus directed scenarios with literal expectations.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   run_cmp = 1'b0;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: the instruction currently sitting in EX, as captured from ID
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [3:0]  aluc;
        logic [2:0]  src;
        logic [3:0]  ctrl;
    } slot_t;

    slot_t m;

    function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] cap);
        if (a == 0) return cap;
        if (bus.exm_wr && bus.exm_dest == a) return bus.exm_data;
        if (bus.wb_wr && bus.wb_dest == a) return bus.wb_data;
        return cap;
    endfunction

    function automatic logic m_lu();
        logic reads;
        reads = (bus.id_use[1] && bus.id_rs_addr == m.dest) ||
                (bus.id_use[0] && bus.id_rt_addr == m.dest);
        return m.v && m.ctrl[2] && (m.dest != 0) && bus.id_valid && reads;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '0;
        end else if (bus.flush) begin
            m.v <= 1'b0;
        end else if (bus.stall_in) begin
            m.rsv <= m_fwd(m.rs, m.rsv);
            m.rtv <= m_fwd(m.rt, m.rtv);
        end else if (m_lu()) begin
            m.v <= 1'b0;
        end else begin
            m <= '{v: bus.id_valid, pc: bus.id_pc, rs: bus.id_rs_addr, rt: bus.id_rt_addr,
                   rsv: bus.id_rs_data, rtv: bus.id_rt_data, dest: bus.id_dest,
                   imm: bus.id_imm, shamt: bus.id_shamt, aluc: bus.id_aluc,
                   src: bus.id_src, ctrl: bus.id_ctrl};
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (run_cmp) begin
            logic [31:0] ea, eb, ext;
            ext = m.src[2] ? 32'($signed(m.imm)) : 32'(m.imm);
            ea  = m.src[1] ? 32'(m.shamt) : m_fwd(m.rs, m.rsv);
            eb  = m.src[0] ? ext : m_fwd(m.rt, m.rtv);
            check("m_stall_out", 32'(bus.stall_out), 32'(bus.stall_in | m_lu()));
            check("m_ex_valid", 32'(bus.ex_valid), 32'(m.v));
            check("m_ex_ctrl", 32'(bus.ex_ctrl), m.v ? 32'(m.ctrl) : 32'd0);
            check("m_ex_pc", bus.ex_pc, m.pc);
            check("m_ex_dest", 32'(bus.ex_dest), 32'(m.dest));
            check("m_alu_aluc", 32'(bus.alu_aluc), 32'(m.aluc));
            check("m_alu_a", bus.alu_a, ea);
            check("m_alu_b", bus.alu_b, eb);
            check("m_store", bus.ex_store_data, m_fwd(m.rt, m.rtv));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [4:0] dest, input logic [15:0] imm,
                          input logic [4:0] shamt, input logic [3:0] aluc,
                          input logic [2:0] src, input logic [3:0] ctrl,
                          input logic [1:0] use_bits);
        bus.id_valid   = v;
        bus.id_pc      = pc;
        bus.id_rs_addr = rs;
        bus.id_rt_addr = rt;
        bus.id_rs_data = rsd;
        bus.id_rt_data = rtd;
        bus.id_dest    = dest;
        bus.id_imm     = imm;
        bus.id_shamt   = shamt;
        bus.id_aluc    = aluc;
        bus.id_src     = src;
        bus.id_ctrl    = ctrl;
        bus.id_use     = use_bits;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] ed, input logic [31:0] edat,
                           input logic ww, input logic [4:0] wd, input logic [31:0] wdat);
        bus.exm_wr   = ew;
        bus.exm_dest = ed;
        bus.exm_data = edat;
        bus.wb_wr    = ww;
        bus.wb_dest  = wd;
        bus.wb_data  = wdat;
    endtask

    initial begin
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 16'h0, 5'd0, 4'h0, 3'b000, 4'h0, 2'b00);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.flush    = 1'b0;
        bus.stall_in = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        run_cmp = 1'b1;
        #1;
        check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        bus.stall_in = 1'b1;
        #1 check("rst_stall_out_1", 32'(bus.stall_out), 32'd1);
        bus.stall_in = 1'b0;
        #1 check("rst_stall_out_0", 32'(bus.stall_out), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // addu $3,$1,$2 : EX/MEM beats MEM/WB
        set_id(1'b1, 32'h100, 5'd1, 5'd2, 32'h111, 32'h222, 5'd3, 16'h0, 5'd0, 4'h2, 3'b000, 4'b1000, 2'b11);
        tick();
        set_id(1'b0, 32'h104, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 16'h0, 5'd0, 4'h0, 3'b000, 4'h0, 2'b00);
        set_fwd(1'b1, 5'd1, 32'h10, 1'b1, 5'd1, 32'h20);
        #1;
        check("prio_alu_a_exm", bus.alu_a, 32'h10);
        check("prio_alu_b", bus.alu_b, 32'h222);
        check("prio_ex_valid", 32'(bus.ex_valid), 32'd1);
        check("prio_ex_pc", bus.ex_pc, 32'h100);
        check("prio_ex_ctrl", 32'(bus.ex_ctrl), 32'h8);
        check("prio_aluc", 32'(bus.alu_aluc), 32'h2);
        bus.exm_wr = 1'b0;
        #1 check("prio_alu_a_wb", bus.alu_a, 32'h20);
        bus.wb_wr = 1'b0;
        #1 check("prio_alu_a_cap", bus.alu_a, 32'h111);

        // $0 is never forwarded
        set_id(1'b1, 32'h108, 5'd0, 5'd2, 32'h0, 32'h222, 5'd3, 16'h0, 5'd0, 4'h2, 3'b000, 4'b1000, 2'b10);
        set_fwd(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0);
        tick();
        check("r0_alu_a", bus.alu_a, 32'h0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Immediates and shift amount
        set_id(1'b1, 32'h10C, 5'd1, 5'd2, 32'h5, 32'h6, 5'd2, 16'h8000, 5'd0, 4'h3, 3'b101, 4'b1000, 2'b10);
        tick();
        check("imm_sext", bus.alu_b, 32'hFFFF8000);
        check("imm_store", bus.ex_store_data, 32'h6);
        bus.id_src = 3'b001;
        tick();
        check("imm_zext", bus.alu_b, 32'h00008000);
        set_id(1'b1, 32'h110, 5'd9, 5'd2, 32'h55, 32'h6, 5'd8, 16'h0, 5'd7, 4'h9, 3'b010, 4'b1000, 2'b01);
        tick();
        check("shamt_alu_a", bus.alu_a, 32'h7);

        // Load-use: lw $5,4($1) then add $6,$5,$5
        set_id(1'b1, 32'h200, 5'd1, 5'd5, 32'h1000, 32'h0, 5'd5, 16'h4, 5'd0, 4'h2, 3'b101, 4'b1101, 2'b10);
        tick();
        set_id(1'b1, 32'h204, 5'd5, 5'd5, 32'h0, 32'h0, 5'd6, 16'h0, 5'd0, 4'h2, 3'b000, 4'b1000, 2'b11);
        #1 check("lu_stall_out", 32'(bus.stall_out), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        check("lu_bubble_ctrl", 32'(bus.ex_ctrl), 32'd0);
        check("lu_stall_once", 32'(bus.stall_out), 32'd0);
        set_fwd(1'b1, 5'd5, 32'h1004, 1'b0, 5'd0, 32'h0);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hCAFE);
        #1;
        check("lu_add_valid", 32'(bus.ex_valid), 32'd1);
        check("lu_add_pc", bus.ex_pc, 32'h204);
        check("lu_add_alu_a", bus.alu_a, 32'hCAFE);
        check("lu_add_alu_b", bus.alu_b, 32'hCAFE);

        // Stall refresh: producer of $4 moves exm -> wb -> retired during stall
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 32'h300, 5'd4, 5'd0, 32'h0, 32'h0, 5'd7, 16'h0, 5'd0, 4'h2, 3'b000, 4'b1000, 2'b10);
        tick();
        bus.stall_in = 1'b1;
        set_fwd(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'h0);
        #1;
        check("st_alu_a_exm", bus.alu_a, 32'h4444);
        check("st_stall_out", 32'(bus.stall_out), 32'd1);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h4444);
        #1 check("st_alu_a_wb", bus.alu_a, 32'h4444);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.stall_in = 1'b0;
        #1;
        check("st_alu_a_kept", bus.alu_a, 32'h4444);
        check("st_ex_valid", 32'(bus.ex_valid), 32'd1);
        check("st_ex_dest", 32'(bus.ex_dest), 32'd7);

        // Flush wins over stall_in
        bus.stall_in = 1'b1;
        bus.flush    = 1'b1;
        tick();
        check("fl_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("fl_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;

        // Reset mid-stream clears outputs without a clock edge
        set_id(1'b1, 32'h400, 5'd1, 5'd2, 32'h1, 32'h2, 5'd3, 16'h0, 5'd0, 4'h5, 3'b000, 4'b1000, 2'b11);
        tick();
        check("mid_ex_valid_pre", 32'(bus.ex_valid), 32'd1);
        check("mid_aluc_pre", 32'(bus.alu_aluc), 32'h5);
        #2 rst = 1'b1;
        #1;
        check("mid_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("mid_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        check("mid_alu_aluc", 32'(bus.alu_aluc), 32'd0);
        check("mid_ex_pc", bus.ex_pc, 32'd0);
        tick();
        rst = 1'b0;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 16'h0, 5'd0, 4'h0, 3'b000, 4'h0, 2'b00);
        tick();
        tick();

        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and EX-stage operand front end for the five-stage MIPS core. It sits directly upstream of the ALU and produces the ALU's two operands and its 4-bit operation code. It captures decoded instructions from ID and applies EX/MEM and MEM/WB forwarding. It detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush.

Parameters:
DW, 32, data/operand width
RW, 5, register address width (also shift-amount width)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_pc  in  32  PC of ID instruction
id_rs_addr  in  RW  rs index
id_rt_addr  in  RW  rt index
id_rs_data  in  DW  register-file rs value (write-through file)
id_rt_data  in  DW  register-file rt value
id_dest  in  RW  destination register index (0 = none)
id_imm  in  16  instruction immediate
id_shamt  in  RW  instruction shamt field
id_aluc  in  4  ALU operation code
id_src  in  3  {sext, a_is_shamt, b_is_imm}
id_ctrl  in  4  {reg_write, mem_read, mem_write, mem_to_reg}
id_use  in  2  {uses_rs, uses_rt}
flush  in  1  branch/jump taken: kill instruction entering EX
stall_in  in  1  downstream (MEM) stall: hold EX contents
exm_wr  in  1  EX/MEM will write a register
exm_dest  in  RW  EX/MEM destination
exm_data  in  DW  EX/MEM result
wb_wr  in  1  MEM/WB will write a register
wb_dest  in  RW  MEM/WB destination
wb_data  in  DW  MEM/WB result
stall_out  out  1  hold IF/ID (combinational)
alu_a  out  DW  ALU operand a (shift amount in low RW bits for shifts)
alu_b  out  DW  ALU operand b
alu_aluc  out  4  registered aluc
ex_valid  out  1  EX holds a real instruction
ex_pc  out  32  registered PC
ex_store_data  out  DW  forwarded rt value for stores
ex_dest  out  RW  registered destination
ex_ctrl  out  4  registered id_ctrl, forced 0 when ex_valid=0

Behaviour:
- Reset: all registers cleared asynchronously. Outputs ex_valid=0, ex_ctrl=0, ex_dest=0, alu_aluc=0, ex_pc=0. alu_a, alu_b and ex_store_data are 0. stall_out=stall_in.
- Load-use hazard: lu = ex_valid & ex_ctrl[mem_read] & ex_dest!=0 & id_valid & ((id_use[1] & id_rs_addr==ex_dest) | (id_use[0] & id_rt_addr==ex_dest)).
- stall_out = stall_in | lu.
- Update priority each clock: flush > stall_in > lu > load.
- Flush: ex_valid<=0, ex_ctrl<=0. This applies even if stall_in=1.
- stall_in: all fields hold. Exception: the rs/rt operand registers are refreshed with their currently forwarded values, so forwarding sources retiring during the stall are not lost.
- lu (without stall_in or flush): a bubble enters EX with ex_valid=0 and ctrl=0. ID is held by stall_out; the next cycle re-evaluates and loads normally, since the load is now in MEM and its result is forwarded from wb next cycle.
- Load: all id_* fields registered; ex_valid<=id_valid; ex_ctrl<=id_valid ? id_ctrl : 0.
- Forwarding (combinational, on registered rs/rt): the exm match wins over the wb match. A match requires wr=1, dest==addr and addr!=0. Register $0 is never forwarded and always reads the captured value.
- alu_a = a_is_shamt ? zero-extended shamt : fwd_rs.
- alu_b = b_is_imm ? ext(imm) : fwd_rt. ext is a sign extension if sext=1, otherwise a zero extension.
- ex_store_data = fwd_rt always.
- Latency: one cycle from ID to the EX outputs. Operand outputs change combinationally with forwarding inputs.

Test Plan:
- Reset mid-stream: assert rst while ex_valid=1 -> ex_valid, ex_ctrl and alu_aluc read 0 immediately, before any clock edge.
- EX/MEM vs MEM/WB priority: addu $3,$1,$2 with rs=1. exm writes $1=0x10 and wb writes $1=0x20 -> alu_a=0x10. With exm_wr=0 -> alu_a=0x20.
- Register $0: rs=0, exm_wr=1, exm_dest=0, exm_data=0xFFFF -> alu_a = captured value (0).
- Immediate: imm=0x8000 with sext=1 -> alu_b=0xFFFF8000. With sext=0 -> alu_b=0x00008000. A shift with shamt=7 -> alu_a=7.
- Load-use: lw $5 in EX, then add $6,$5,$5 in ID -> stall_out=1 for exactly one cycle and one bubble (ex_valid=0). Next cycle the add enters EX with alu_a=wb_data of the load.
- Stall refresh: stall_in held 2 cycles while the exm producer of $4 moves to wb and then retires. After release, alu_a still equals the produced value. flush during stall_in -> ex_valid=0 next edge.
